// File: rtl/card_reveal_ctrl.sv
// card_reveal_ctrl: memory-game reveal sequencer driving per-card draw_rect enables.
// Tracks up to two face-up cards, holds a pair for SHOW_FRAMES frames, then
// keeps it shown on a match or hides it on a mismatch. The enables are only
// updated on frame_tick, so a card never changes state partway through a frame.
module card_reveal_ctrl #(
  parameter int unsigned NUM_CARDS   = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned VAL_W       = 3,
  parameter int unsigned SHOW_FRAMES = 60
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [NUM_CARDS*VAL_W-1:0] card_values,
  input  logic                       new_game,
  input  logic                       sel_valid,
  input  logic [IDX_W-1:0]           sel_idx,
  output logic                       sel_ready,
  output logic [NUM_CARDS-1:0]       enable_mask,
  output logic [NUM_CARDS-1:0]       matched_mask,
  output logic                       match_pulse,
  output logic                       mismatch_pulse,
  output logic [7:0]                 moves,
  output logic                       game_done
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE_UP,
    S_SHOW,
    S_EVAL,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     first_q, first_d;
  logic [IDX_W-1:0]     second_q, second_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CARDS-1:0] shown_q, shown_d;
  logic [NUM_CARDS-1:0] matched_q, matched_d;
  logic [NUM_CARDS-1:0] enable_q, enable_d;
  logic [7:0]           moves_q, moves_d;
  logic                 match_q, match_d;
  logic                 mismatch_q, mismatch_d;
  logic                 done_q, done_d;

  logic [NUM_CARDS-1:0] sel_bit, first_bit, second_bit;
  logic [VAL_W-1:0]     first_val, second_val;
  logic                 in_range, accept;

  // Selection decode: one-hot of the candidate card and the accept qualifier.
  always_comb begin
    sel_ready  = (state_q == S_IDLE) || (state_q == S_ONE_UP);
    sel_bit    = NUM_CARDS'(1) << sel_idx;
    first_bit  = NUM_CARDS'(1) << first_q;
    second_bit = NUM_CARDS'(1) << second_q;
    in_range   = 32'(sel_idx) < NUM_CARDS;
    accept     = sel_valid && sel_ready && in_range &&
                 !(|(sel_bit & matched_q)) &&
                 ((state_q != S_ONE_UP) || (sel_idx != first_q));
  end

  // Face-value lookup of the two revealed cards (index compare avoids wide index math).
  always_comb begin
    first_val  = '0;
    second_val = '0;
    for (int i = 0; i < int'(NUM_CARDS); i++) begin
      if (IDX_W'(i) == first_q)  first_val  = card_values[i*VAL_W +: VAL_W];
      if (IDX_W'(i) == second_q) second_val = card_values[i*VAL_W +: VAL_W];
    end
  end

  // Next-state and datapath update; new_game overrides everything except the enable load.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    second_d   = second_q;
    cnt_d      = cnt_q;
    shown_d    = shown_q;
    matched_d  = matched_q;
    moves_d    = moves_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    done_d     = done_q;
    enable_d   = frame_tick ? (shown_q | matched_q) : enable_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          first_d = sel_idx;
          shown_d = shown_q | sel_bit;
          state_d = S_ONE_UP;
        end
      end
      S_ONE_UP: begin
        if (accept) begin
          second_d = sel_idx;
          shown_d  = shown_q | sel_bit;
          cnt_d    = '0;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SHOW_FRAMES - 1)) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
        if (first_val == second_val) begin
          matched_d = matched_q | first_bit | second_bit;
          match_d   = 1'b1;
        end else begin
          shown_d    = shown_q & ~(first_bit | second_bit);
          mismatch_d = 1'b1;
        end
        if (&matched_d) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (new_game) begin
      state_d    = S_IDLE;
      shown_d    = '0;
      matched_d  = '0;
      moves_d    = '0;
      done_d     = 1'b0;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      first_q    <= '0;
      second_q   <= '0;
      cnt_q      <= '0;
      shown_q    <= '0;
      matched_q  <= '0;
      enable_q   <= '0;
      moves_q    <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      second_q   <= second_d;
      cnt_q      <= cnt_d;
      shown_q    <= shown_d;
      matched_q  <= matched_d;
      enable_q   <= enable_d;
      moves_q    <= moves_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
    end
  end

  assign enable_mask    = enable_q;
  assign matched_mask   = matched_q;
  assign match_pulse    = match_q;
  assign mismatch_pulse = mismatch_q;
  assign moves          = moves_q;
  assign game_done      = done_q;

endmodule
